// File: rtl/rmt_classifier.sv
// AXI-Stream classifier: matches EtherType/delimiter/function fields on the first beat,
// selects tdest from a runtime rule table, drops non-matching frames, keeps statistics.
`timescale 1ns/1ps
module rmt_classifier #(
    parameter int DATA_WIDTH   = 512,
    parameter int KEEP_WIDTH   = DATA_WIDTH/8,
    parameter int USER_WIDTH   = 8,
    parameter int DEST_WIDTH   = 2,
    parameter int RULE_COUNT   = 4,
    parameter int ETYPE_OFFSET = 12,
    parameter logic [15:0] ETYPE_MATCH = 16'h0008,
    parameter int DELIM_OFFSET = 42,
    parameter logic [15:0] DELIM_MATCH = 16'hF0E1,
    parameter int FUNC_OFFSET  = 44,
    parameter int DEFAULT_DEST = 0,
    parameter int DROP_MISS    = 0,
    parameter int CNT_WIDTH    = 32,
    localparam int IDX_W = (RULE_COUNT > 1) ? $clog2(RULE_COUNT) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic [DEST_WIDTH-1:0] m_axis_tdest,
    input  logic                  cfg_wr_en,
    input  logic [IDX_W-1:0]      cfg_wr_idx,
    input  logic [15:0]           cfg_wr_func,
    input  logic [DEST_WIDTH-1:0] cfg_wr_dest,
    input  logic                  cfg_wr_enable,
    input  logic                  stat_clear,
    output logic [CNT_WIDTH-1:0]  stat_fwd_pkts,
    output logic [CNT_WIDTH-1:0]  stat_drop_pkts,
    output logic [CNT_WIDTH-1:0]  stat_miss_pkts
);

    typedef enum logic [1:0] {IDLE, FORWARD, DROP} state_t;

    state_t state_reg, state_next;
    logic [DEST_WIDTH-1:0] dest_reg, dest_next;

    logic [15:0]           rule_func_reg [RULE_COUNT];
    logic [DEST_WIDTH-1:0] rule_dest_reg [RULE_COUNT];
    logic [RULE_COUNT-1:0] rule_en_reg;
    logic [RULE_COUNT-1:0] rule_hit;
    logic                  hit_any;
    logic [DEST_WIDTH-1:0] hit_dest;

    // Fields are taken in wire byte order: byte k of the beat lives in tdata[8k+7:8k]
    logic [15:0] hdr_etype, hdr_delim, hdr_func;
    logic        hdr_match;
    assign hdr_etype = s_axis_tdata[8*ETYPE_OFFSET +: 16];
    assign hdr_delim = s_axis_tdata[8*DELIM_OFFSET +: 16];
    assign hdr_func  = s_axis_tdata[8*FUNC_OFFSET +: 16];
    assign hdr_match = (hdr_etype == ETYPE_MATCH) && (hdr_delim == DELIM_MATCH);

    generate
        for (genvar gi = 0; gi < RULE_COUNT; gi++) begin : g_rule
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rule_func_reg[gi] <= '0;
                    rule_dest_reg[gi] <= '0;
                    rule_en_reg[gi]   <= 1'b0;
                end else if (cfg_wr_en && (cfg_wr_idx == IDX_W'(gi))) begin
                    rule_func_reg[gi] <= cfg_wr_func;
                    rule_dest_reg[gi] <= cfg_wr_dest;
                    rule_en_reg[gi]   <= cfg_wr_enable;
                end
            end
            assign rule_hit[gi] = rule_en_reg[gi] && (rule_func_reg[gi] == hdr_func);
        end
    endgenerate

    // Walk from the top so the lowest-index hit wins
    always_comb begin
        hit_any  = 1'b0;
        hit_dest = '0;
        for (int i = RULE_COUNT - 1; i >= 0; i--) begin
            if (rule_hit[i]) begin
                hit_any  = 1'b1;
                hit_dest = rule_dest_reg[i];
            end
        end
    end

    logic ready_reg;
    logic accept;
    logic fwd_beat;
    logic [DEST_WIDTH-1:0] beat_dest;
    logic inc_fwd, inc_drop, inc_miss;

    assign accept = s_axis_tvalid && ready_reg;

    always_comb begin
        state_next = state_reg;
        dest_next  = dest_reg;
        beat_dest  = dest_reg;
        fwd_beat   = 1'b0;
        inc_fwd    = 1'b0;
        inc_drop   = 1'b0;
        inc_miss   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    inc_miss = hdr_match && !hit_any;
                    if (hdr_match && (hit_any || DROP_MISS == 0)) begin
                        fwd_beat  = 1'b1;
                        beat_dest = hit_any ? hit_dest : DEST_WIDTH'(DEFAULT_DEST);
                        dest_next = beat_dest;
                        inc_fwd   = 1'b1;
                        if (!s_axis_tlast) state_next = FORWARD;
                    end else begin
                        inc_drop = 1'b1;
                        if (!s_axis_tlast) state_next = DROP;
                    end
                end
            end
            FORWARD: begin
                fwd_beat = accept;
                if (accept && s_axis_tlast) state_next = IDLE;
            end
            DROP: begin
                if (accept && s_axis_tlast) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            dest_reg  <= '0;
        end else begin
            state_reg <= state_next;
            dest_reg  <= dest_next;
        end
    end

    logic [DATA_WIDTH-1:0] out_data_reg, skid_data_reg;
    logic [KEEP_WIDTH-1:0] out_keep_reg, skid_keep_reg;
    logic [USER_WIDTH-1:0] out_user_reg, skid_user_reg;
    logic [DEST_WIDTH-1:0] out_dest_reg, skid_dest_reg;
    logic                  out_last_reg, skid_last_reg;
    logic                  out_valid_reg, skid_valid_reg;
    logic                  out_ready;
    logic                  skid_valid_next;

    assign out_ready       = !out_valid_reg || m_axis_tready;
    assign skid_valid_next = out_ready ? 1'b0 : (skid_valid_reg || fwd_beat);

    // Skid only fills while the output is stalled; ready reflects an empty skid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_reg   <= '0;
            out_keep_reg   <= '0;
            out_user_reg   <= '0;
            out_dest_reg   <= '0;
            out_last_reg   <= 1'b0;
            out_valid_reg  <= 1'b0;
            skid_data_reg  <= '0;
            skid_keep_reg  <= '0;
            skid_user_reg  <= '0;
            skid_dest_reg  <= '0;
            skid_last_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
            ready_reg      <= 1'b0;
        end else begin
            ready_reg      <= !skid_valid_next;
            skid_valid_reg <= skid_valid_next;
            if (out_ready) begin
                if (skid_valid_reg) begin
                    out_data_reg  <= skid_data_reg;
                    out_keep_reg  <= skid_keep_reg;
                    out_user_reg  <= skid_user_reg;
                    out_dest_reg  <= skid_dest_reg;
                    out_last_reg  <= skid_last_reg;
                    out_valid_reg <= 1'b1;
                end else if (fwd_beat) begin
                    out_data_reg  <= s_axis_tdata;
                    out_keep_reg  <= s_axis_tkeep;
                    out_user_reg  <= s_axis_tuser;
                    out_dest_reg  <= beat_dest;
                    out_last_reg  <= s_axis_tlast;
                    out_valid_reg <= 1'b1;
                end else begin
                    out_valid_reg <= 1'b0;
                end
            end else if (fwd_beat) begin
                skid_data_reg <= s_axis_tdata;
                skid_keep_reg <= s_axis_tkeep;
                skid_user_reg <= s_axis_tuser;
                skid_dest_reg <= beat_dest;
                skid_last_reg <= s_axis_tlast;
            end
        end
    end

    assign s_axis_tready = ready_reg;
    assign m_axis_tdata  = out_data_reg;
    assign m_axis_tkeep  = out_keep_reg;
    assign m_axis_tuser  = out_user_reg;
    assign m_axis_tdest  = out_dest_reg;
    assign m_axis_tlast  = out_last_reg;
    assign m_axis_tvalid = out_valid_reg;

    logic [CNT_WIDTH-1:0] cnt_reg [3];
    logic [2:0]           cnt_inc;
    assign cnt_inc = {inc_miss, inc_drop, inc_fwd};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg[gi] <= '0;
                end else if (stat_clear) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_WIDTH{1'b1}})) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign stat_fwd_pkts  = cnt_reg[0];
    assign stat_drop_pkts = cnt_reg[1];
    assign stat_miss_pkts = cnt_reg[2];

endmodule

// File: tb/tb_rmt_classifier.sv
// Self-checking bench for rmt_classifier: vector table of frames, scoreboard of forwarded
// beats, plus hand sequences for latency, rule updates, counter clear/saturation and reset.
`timescale 1ns/1ps
module tb_rmt_classifier;
    localparam int DW = 512;
    localparam int KW = 64;
    localparam int UW = 8;
    localparam int DSW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0]  s_tdata, m_tdata, m2_tdata;
    logic [KW-1:0]  s_tkeep, m_tkeep, m2_tkeep;
    logic [UW-1:0]  s_tuser, m_tuser, m2_tuser;
    logic [DSW-1:0] m_tdest, m2_tdest;
    logic s_tvalid, s_tready, s_tlast, m_tvalid, m_tready, m_tlast;
    logic s2_tvalid, s2_tready, m2_tvalid, m2_tlast;
    logic cfg_wr_en, cfg_wr_enable, stat_clear;
    logic [1:0]  cfg_wr_idx;
    logic [15:0] cfg_wr_func;
    logic [DSW-1:0] cfg_wr_dest;
    logic [31:0] stat_fwd, stat_drop, stat_miss;
    logic [1:0]  st2_fwd, st2_drop, st2_miss;

    rmt_classifier #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .m_axis_tdest(m_tdest),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_idx(cfg_wr_idx), .cfg_wr_func(cfg_wr_func),
        .cfg_wr_dest(cfg_wr_dest), .cfg_wr_enable(cfg_wr_enable), .stat_clear(stat_clear),
        .stat_fwd_pkts(stat_fwd), .stat_drop_pkts(stat_drop), .stat_miss_pkts(stat_miss)
    );

    // Second instance: drop-on-miss with 2-bit counters, fed exactly the beats the first accepts
    assign s2_tvalid = s_tvalid && s_tready;
    rmt_classifier #(.DATA_WIDTH(DW), .DROP_MISS(1), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s2_tvalid),
        .s_axis_tready(s2_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m2_tdata), .m_axis_tkeep(m2_tkeep), .m_axis_tvalid(m2_tvalid),
        .m_axis_tready(1'b1), .m_axis_tlast(m2_tlast), .m_axis_tuser(m2_tuser),
        .m_axis_tdest(m2_tdest),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_idx(cfg_wr_idx), .cfg_wr_func(cfg_wr_func),
        .cfg_wr_dest(cfg_wr_dest), .cfg_wr_enable(cfg_wr_enable), .stat_clear(stat_clear),
        .stat_fwd_pkts(st2_fwd), .stat_drop_pkts(st2_drop), .stat_miss_pkts(st2_miss)
    );

    typedef struct {
        logic [DW-1:0]  d;
        logic [KW-1:0]  k;
        logic           l;
        logic [UW-1:0]  u;
        logic [DSW-1:0] dest;
    } beat_t;

    typedef struct {
        logic [15:0]    et;
        logic [15:0]    dl;
        logic [15:0]    fn;
        int             nb;
        logic           fwd;
        logic [DSW-1:0] dest;
        logic           miss;
    } vec_t;

    beat_t sb[$];
    int tests = 0;
    int fails = 0;
    int e_fwd = 0, e_drop = 0, e_miss = 0;
    int ready_mode = 0;
    bit chk_ready = 0;

    function automatic void chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW/32; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    // Output-ready driver: 0 = always ready, 1 = random 50%, 2 = stalled
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       m_tready = 1'($urandom_range(0, 1));
                2:       m_tready = 1'b0;
                default: m_tready = 1'b1;
            endcase
        end
    end

    // Monitor: scoreboard pop, stall stability, and ready-only-drops-after-stall
    initial begin
        bit pst;
        beat_t pb;
        beat_t e;
        pst = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pst = 0;
            end else begin
                if (chk_ready && !pst) chk("s_tready_without_stall", s_tready, 1);
                if (pst) begin
                    chk("hold_valid", m_tvalid, 1);
                    chk("hold_data", m_tdata, pb.d);
                    chk("hold_dest", m_tdest, pb.dest);
                end
                if (m_tvalid && m_tready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_beat", m_tvalid, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", m_tdata, e.d);
                        chk("out_keep", m_tkeep, e.k);
                        chk("out_last", m_tlast, e.l);
                        chk("out_user", m_tuser, e.u);
                        chk("out_dest", m_tdest, e.dest);
                    end
                end
                pst = m_tvalid && !m_tready;
                pb.d = m_tdata;
                pb.dest = m_tdest;
            end
        end
    end

    task automatic send_beat(input beat_t x);
        int t;
        bit acc;
        s_tdata = x.d;
        s_tkeep = x.k;
        s_tlast = x.l;
        s_tuser = x.u;
        s_tvalid = 1'b1;
        t = 0;
        acc = 0;
        while (!acc && t < 500) begin
            @(negedge clk);
            acc = s_tready;
            @(posedge clk);
            #1;
            t++;
        end
        chk("accept_timeout", acc, 1);
    endtask

    task automatic send_frame(input logic [15:0] et, input logic [15:0] dl, input logic [15:0] fn,
                              input int nb, input logic fwd, input logic [DSW-1:0] dest,
                              input logic miss, input int wr_beat);
        for (int b = 0; b < nb; b++) begin
            beat_t x;
            x.d = rand_data();
            if (b == 0) begin
                x.d[8*12 +: 16] = et;
                x.d[8*42 +: 16] = dl;
                x.d[8*44 +: 16] = fn;
            end
            x.k = (b == nb - 1) ? {$urandom, $urandom} : '1;
            x.l = (b == nb - 1);
            x.u = UW'($urandom);
            x.dest = dest;
            if (fwd) sb.push_back(x);
            if (b == wr_beat) cfg_wr_en = 1'b1;
            send_beat(x);
            cfg_wr_en = 1'b0;
        end
        if (fwd) e_fwd++; else e_drop++;
        if (miss) e_miss++;
        $display("[TB] frame etype=%h delim=%h func=%h beats=%0d %s dest=%0d",
                 et, dl, fn, nb, fwd ? "forward" : "drop", dest);
    endtask

    task automatic wr_rule(input int idx, input logic [15:0] fn, input logic [DSW-1:0] d, input logic en);
        cfg_wr_idx = 2'(idx);
        cfg_wr_func = fn;
        cfg_wr_dest = d;
        cfg_wr_enable = en;
        cfg_wr_en = 1'b1;
        @(posedge clk);
        #1;
        cfg_wr_en = 1'b0;
    endtask

    task automatic drain();
        int t;
        s_tvalid = 1'b0;
        t = 0;
        while (sb.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drain_queue_empty", sb.size(), 0);
    endtask

    task automatic chk_counters(string tag);
        chk({tag, "_fwd"}, stat_fwd, e_fwd);
        chk({tag, "_drop"}, stat_drop, e_drop);
        chk({tag, "_miss"}, stat_miss, e_miss);
    endtask

    vec_t vt [6];

    initial begin
        beat_t b;
        vt[0] = '{16'h0008, 16'hF0E1, 16'h0001, 3, 1'b1, 2'd1, 1'b0};
        vt[1] = '{16'hDD86, 16'hF0E1, 16'h0001, 4, 1'b0, 2'd0, 1'b0};
        vt[2] = '{16'h0008, 16'hF0E1, 16'h0001, 2, 1'b1, 2'd1, 1'b0};
        vt[3] = '{16'h0008, 16'hF0E1, 16'h0007, 2, 1'b1, 2'd0, 1'b1};
        vt[4] = '{16'h0008, 16'h1234, 16'h0001, 1, 1'b0, 2'd0, 1'b0};
        vt[5] = '{16'h0008, 16'hF0E1, 16'h0001, 1, 1'b1, 2'd1, 1'b0};

        s_tvalid = 0; s_tdata = '0; s_tkeep = '0; s_tlast = 0; s_tuser = '0;
        cfg_wr_en = 0; cfg_wr_idx = '0; cfg_wr_func = '0; cfg_wr_dest = '0; cfg_wr_enable = 0;
        stat_clear = 0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_fwd_cnt", stat_fwd, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release_s_tready", s_tready, 1);
        @(posedge clk);
        #1;
        chk_ready = 1;
        wr_rule(0, 16'h0001, 2'd1, 1'b1);

        // One-cycle latency from acceptance to valid
        b.d = rand_data();
        b.d[8*12 +: 16] = 16'h0008;
        b.d[8*42 +: 16] = 16'hF0E1;
        b.d[8*44 +: 16] = 16'h0001;
        b.k = '1; b.l = 1'b1; b.u = 8'h5A; b.dest = 2'd1;
        sb.push_back(b);
        s_tdata = b.d; s_tkeep = b.k; s_tlast = b.l; s_tuser = b.u; s_tvalid = 1'b1;
        @(negedge clk);
        chk("lat_accept_ready", s_tready, 1);
        chk("lat_not_yet_valid", m_tvalid, 0);
        @(posedge clk);
        #1 s_tvalid = 1'b0;
        @(negedge clk);
        chk("lat_valid_next_cycle", m_tvalid, 1);
        chk("lat_dest", m_tdest, 1);
        @(posedge clk);
        #1;
        e_fwd = 1;

        // Vector table
        for (int i = 0; i < 6; i++) begin
            send_frame(vt[i].et, vt[i].dl, vt[i].fn, vt[i].nb, vt[i].fwd, vt[i].dest, vt[i].miss, -1);
            drain();
            chk_counters($sformatf("vec%0d", i));
        end

        // Miss handling on both instances after a counter clear
        stat_clear = 1'b1;
        @(posedge clk);
        #1 stat_clear = 1'b0;
        e_fwd = 0; e_drop = 0; e_miss = 0;
        send_frame(16'h0008, 16'hF0E1, 16'h0007, 2, 1'b1, 2'd0, 1'b1, -1);
        drain();
        chk_counters("miss");
        chk("dropmiss_miss", st2_miss, 1);
        chk("dropmiss_drop", st2_drop, 1);
        chk("dropmiss_fwd", st2_fwd, 0);

        // Lowest-index rule wins; mid-frame write leaves current frame alone; same-cycle write uses old table
        wr_rule(2, 16'h0001, 2'd3, 1'b1);
        send_frame(16'h0008, 16'hF0E1, 16'h0001, 2, 1'b1, 2'd1, 1'b0, -1);
        cfg_wr_idx = 2'd0; cfg_wr_func = 16'h0001; cfg_wr_dest = 2'd2; cfg_wr_enable = 1'b1;
        send_frame(16'h0008, 16'hF0E1, 16'h0001, 3, 1'b1, 2'd1, 1'b0, 1);
        cfg_wr_dest = 2'd3;
        send_frame(16'h0008, 16'hF0E1, 16'h0001, 2, 1'b1, 2'd2, 1'b0, 0);
        send_frame(16'h0008, 16'hF0E1, 16'h0001, 2, 1'b1, 2'd3, 1'b0, -1);
        drain();
        chk_counters("prio");

        // Back-to-back random frames under random backpressure
        ready_mode = 1;
        for (int f = 0; f < 100; f++) begin
            int ty;
            int nb;
            ty = $urandom_range(0, 3);
            nb = $urandom_range(1, 8);
            case (ty)
                0:       send_frame(16'h0008, 16'hF0E1, 16'h0001, nb, 1'b1, 2'd3, 1'b0, -1);
                1:       send_frame(16'h0008, 16'hF0E1, 16'h0007, nb, 1'b1, 2'd0, 1'b1, -1);
                2:       send_frame(16'hDD86, 16'hF0E1, 16'h0001, nb, 1'b0, 2'd0, 1'b0, -1);
                default: send_frame(16'h0008, 16'h0000, 16'h0001, nb, 1'b0, 2'd0, 1'b0, -1);
            endcase
        end
        drain();
        ready_mode = 0;
        chk_counters("random");
        chk("sat_fwd_2bit", st2_fwd, 2'b11);
        chk("sat_drop_2bit", st2_drop, 2'b11);

        // Clear wins over a same-cycle increment
        stat_clear = 1'b1;
        send_frame(16'h0008, 16'hF0E1, 16'h0001, 1, 1'b1, 2'd3, 1'b0, -1);
        stat_clear = 1'b0;
        e_fwd = 0; e_drop = 0; e_miss = 0;
        drain();
        chk_counters("clear_prio");
        chk("clear_prio_dut2_fwd", st2_fwd, 0);

        // Asynchronous reset mid-frame with the output stalled and skid full
        chk_ready = 0;
        ready_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        b.d = rand_data(); b.d[8*12 +: 16] = 16'h0008; b.d[8*42 +: 16] = 16'hF0E1;
        b.d[8*44 +: 16] = 16'h0001; b.l = 1'b0;
        send_beat(b);
        b.d = rand_data();
        send_beat(b);
        @(negedge clk);
        chk("stall_skid_ready_low", s_tready, 0);
        chk("stall_valid_held", m_tvalid, 1);
        #2 rst_n = 1'b0;
        s_tvalid = 1'b0;
        #1;
        chk("async_rst_m_tvalid", m_tvalid, 0);
        chk("async_rst_s_tready", s_tready, 0);
        sb.delete();
        e_fwd = 0; e_drop = 0; e_miss = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ready_mode = 0;
        @(posedge clk);
        #1;
        chk_counters("post_rst");
        wr_rule(0, 16'h0001, 2'd2, 1'b1);
        send_frame(16'h0008, 16'hF0E1, 16'h0001, 3, 1'b1, 2'd2, 1'b0, -1);
        drain();
        chk_counters("post_rst_frame");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
